lsu_dm_port: RTL and testbench

- Load/store front-end that sits directly upstream of the word-only data memory.
- Accepts byte, half and word load/store requests from the execute stage.
- Checks alignment and address range, then drives the memory's word interface (address, W_data, REn/WEn, valid strobe).
- Performs read-modify-write for sub-word stores, and lane-extracts plus sign/zero-extends load data before returning a single-cycle response.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/lsu_dm_port.sv | 140 ++++++++++++++
 tb/tb_lsu_dm_port.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store data-memory port.
package lsu_pkg;

   // Access size encoding as presented by the execute stage
   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_BAD = 2'b11
   } size_e;

   // Port sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_RESP
   } state_e;

   localparam logic [31:0] LSU_START_ADDR = 32'h8000_0000;
   localparam int          LSU_NUM_WORDS  = 4096;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering between a 32-bit memory word and sub-word load/store data.
// Loads: pick the addressed byte/half and sign- or zero-extend it.
// Stores: replace the addressed lane(s) of the memory word with new data.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_word
);

   logic        [7:0]  b_raw;
   logic        [15:0] h_raw;
   logic signed [7:0]  b_s;
   logic signed [15:0] h_s;
   logic signed [31:0] b_ext;
   logic signed [31:0] h_ext;

   // Little-endian lane selection: byte lane = addr[1:0], half lane = addr[1]
   assign b_raw = mem_word[{lane, 3'b000} +: 8];
   assign h_raw = mem_word[{lane[1], 4'b0000} +: 16];
   assign b_s   = b_raw;
   assign h_s   = h_raw;
   assign b_ext = 32'(b_s);
   assign h_ext = 32'(h_s);

   // Load extraction and extension
   always_comb begin
      ld_data = mem_word;
      case (size)
         SZ_B:    ld_data = is_unsigned ? {24'h0, b_raw} : b_ext;
         SZ_H:    ld_data = is_unsigned ? {16'h0, h_raw} : h_ext;
         default: ld_data = mem_word;
      endcase
   end

   // Store merge: untouched lanes keep the word just read from memory
   always_comb begin
      st_word = wdata;
      case (size)
         SZ_B: begin
            st_word = mem_word;
            st_word[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_H: begin
            st_word = mem_word;
            st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: st_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_dm_port.sv
// Load/store front-end for a word-only data memory: checks requests,
// sequences read / read-modify-write / write accesses, and returns one
// registered response pulse per accepted request.
module lsu_dm_port
   import lsu_pkg::*;
#(
   parameter logic [31:0] START_ADDR = LSU_START_ADDR,
   parameter int          NUM_WORDS  = LSU_NUM_WORDS,
   parameter int          DM_LAT     = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_ren,
   output logic        dm_wen,
   output logic        dm_valid,
   input  logic [31:0] dm_rdata,
   input  logic        dm_err
);

   // One past the last mapped byte, in 33 bits so the top of the map cannot wrap
   localparam logic [32:0] END_ADDR = {1'b0, START_ADDR} + (33'(NUM_WORDS) << 2);

   state_e      state, state_n;
   size_e       req_sz;
   size_e       size_q;
   logic        we_q, uns_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  cnt;
   logic        accept, bad, last_wait, rsp_err_n;
   logic [31:0] cur_addr, ld_data, st_word;

   assign req_sz    = size_e'(req_size);
   assign accept    = (state == ST_IDLE) && req_ready && req_valid;
   assign last_wait = (state == ST_WAIT) && (cnt == 3'd0);
   assign cur_addr  = (state == ST_IDLE) ? req_addr : addr_q;
   assign rsp_err_n = ((state == ST_IDLE) && bad) || (last_wait && dm_err);

   // Acceptance checks: size legality, natural alignment, address window
   always_comb begin
      bad = 1'b0;
      case (req_sz)
         SZ_BAD:  bad = 1'b1;
         SZ_H:    bad = req_addr[0];
         SZ_W:    bad = |req_addr[1:0];
         default: bad = 1'b0;
      endcase
      if ({1'b0, req_addr} < {1'b0, START_ADDR}) bad = 1'b1;
      if ({1'b0, req_addr} >= END_ADDR)          bad = 1'b1;
   end

   // Next-state: loads and sub-word stores read first, word stores write directly
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (bad)                          state_n = ST_RESP;
               else if (req_we && req_sz == SZ_W) state_n = ST_WR;
               else                              state_n = ST_RD;
            end
         end
         ST_RD:   state_n = ST_WAIT;
         ST_WAIT: begin
            if (last_wait) state_n = (we_q && !dm_err) ? ST_WR : ST_RESP;
         end
         ST_WR:   state_n = ST_RESP;
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // State, latency counter and all registered outputs (driven from next state)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         req_ready <= 1'b0;
         dm_valid  <= 1'b0;
         dm_ren    <= 1'b0;
         dm_wen    <= 1'b0;
         dm_addr   <= 32'h0;
         dm_wdata  <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         state     <= state_n;
         req_ready <= (state_n == ST_IDLE);
         if (state == ST_RD)
            cnt <= 3'(DM_LAT - 1);
         else if ((state == ST_WAIT) && (cnt != 3'd0))
            cnt <= cnt - 3'd1;
         dm_ren    <= (state_n == ST_RD);
         dm_wen    <= (state_n == ST_WR);
         dm_valid  <= (state_n == ST_RD) || (state_n == ST_WR);
         dm_addr   <= ((state_n == ST_RD) || (state_n == ST_WR)) ?
                      {cur_addr[31:2], 2'b00} : 32'h0;
         dm_wdata  <= (state_n != ST_WR)   ? 32'h0 :
                      (state == ST_IDLE)   ? req_wdata : st_word;
         rsp_valid <= (state_n == ST_RESP);
         rsp_err   <= (state_n == ST_RESP) && rsp_err_n;
         rsp_rdata <= ((state_n == ST_RESP) && last_wait && !we_q && !dm_err) ?
                      ld_data : 32'h0;
      end
   end

   // Request fields held for the whole transaction; data only, no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         size_q  <= req_sz;
         uns_q   <= req_unsigned;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   lsu_lane_align u_align (
      .size        (size_q),
      .lane        (addr_q[1:0]),
      .is_unsigned (uns_q),
      .mem_word    (dm_rdata),
      .wdata       (wdata_q),
      .ld_data     (ld_data),
      .st_word     (st_word)
   );

endmodule

// File: tb/tb_lsu_dm_port.sv
// Bench for lsu_dm_port: directed vector table, reset-in-flight sequence and
// randomized traffic against a byte-level reference model and memory.
module tb_lsu_dm_port;

   localparam longint TB_START = 64'h8000_0000;
   localparam int     TB_NW    = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_ren, dm_wen, dm_valid, dm_err;

   lsu_dm_port dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ren(dm_ren), .dm_wen(dm_wen),
      .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err)
   );

   always #5 clk = ~clk;

   // Memory model (one-cycle read latency) plus strobe protocol monitor
   logic [31:0] mem     [0:TB_NW-1];
   logic [31:0] ref_mem [0:TB_NW-1];
   logic        init_en, pre_en, err_arm;
   int          pre_idx;
   logic [31:0] pre_val;
   logic        proto_bad = 1'b0;
   wire  [31:0] dm_off = dm_addr - 32'h8000_0000;
   wire         dm_inr = dm_off < 32'h4000;

   function automatic logic [31:0] hash(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
   endfunction

   always @(posedge clk) begin
      if (init_en) for (int i = 0; i < TB_NW; i++) mem[i] <= hash(i);
      else if (pre_en) mem[pre_idx] <= pre_val;
      if (dm_valid && dm_wen && dm_inr) mem[dm_off[13:2]] <= dm_wdata;
      if (dm_valid && dm_ren) begin
         dm_rdata <= dm_inr ? mem[dm_off[13:2]] : 32'h0;
         dm_err   <= err_arm;
      end else begin
         dm_err   <= 1'b0;
      end
      if ((dm_valid !== (dm_ren | dm_wen)) || (dm_ren && dm_wen)) proto_bad <= 1'b1;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
      end
   endtask

   // Results of the last transaction
   logic [31:0] r_rdata, r_wd, r_da;
   logic        r_err, r_dmv, r_wen, r_pulse_ok;
   int          r_lat;

   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic inj);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!req_ready) check("ready_wait", 0, 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; err_arm = inj;
      @(posedge clk); #1;
      req_we = 1'($urandom); req_size = 2'($urandom_range(3, 0));
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      r_lat = -1; r_dmv = 0; r_wen = 0; r_wd = 0; r_da = 0; r_rdata = 0; r_err = 0; r_pulse_ok = 0;
      for (int c = 1; c <= 20; c++) begin
         req_valid = 1'($urandom);
         if (dm_valid) begin r_dmv = 1; r_da = dm_addr; end
         if (dm_wen)   begin r_wen = 1; r_wd = dm_wdata; end
         if (rsp_valid) begin r_lat = c; r_rdata = rsp_rdata; r_err = rsp_err; break; end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (r_lat > 0) begin @(posedge clk); #1; r_pulse_ok = !rsp_valid && req_ready; end
      err_arm = 1'b0;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      pre_idx = int'((longint'(addr) - TB_START) / 4);
      pre_val = val; pre_en = 1'b1;
      @(posedge clk); #1;
      pre_en = 1'b0;
      ref_mem[pre_idx] = val;
   endtask

   // Reference: byte-addressed view of the access, latency from the access kind
   function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic inj,
                                 output logic e, output logic [31:0] rd, output int lat,
                                 output int widx, output logic wrote);
      longint a, m, v;
      int nb, sh;
      a = longint'(addr);
      e = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
          (a < TB_START) || (a >= TB_START + 4 * TB_NW);
      rd = 0; wrote = 0; widx = 0; lat = 1;
      if (e) return;
      widx = int'((a - TB_START) / 4);
      nb = 1 << sz;
      sh = int'(a % 4) * 8;
      m  = (64'd1 << (8 * nb)) - 1;
      if (we && sz == 2'd2) begin ref_mem[widx] = wdata; lat = 2; wrote = 1; return; end
      lat = 3;
      if (inj) begin e = 1; return; end
      if (!we) begin
         v = (longint'(ref_mem[widx]) >> sh) & m;
         if (!uns && v[8 * nb - 1]) v = v | ~m;
         rd = v[31:0];
      end else begin
         v = (longint'(ref_mem[widx]) & ~(m << sh)) | ((longint'(wdata) & m) << sh);
         ref_mem[widx] = v[31:0];
         lat = 4; wrote = 1;
      end
   endfunction

   typedef struct {
      logic we; logic [1:0] sz; logic uns; logic [31:0] addr; logic [31:0] wdata; logic inj;
      logic pre; logic [31:0] pv;
      logic err; logic [31:0] rdata; int lat; logic dmv; logic wen; logic [31:0] wd;
   } vec_t;

   vec_t        tbl [16];
   logic        m_e, m_wrote, we, uns, inj, saw;
   logic [31:0] m_rd, addr, wdata;
   logic [1:0]  sz;
   int          m_lat, m_idx;

   initial begin
      tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 32'h0, 4, 1'b1, 1'b1, 32'h1122_A544};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1122_A544, 3, 1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0011, 32'h0, 1'b0, 1'b1, 32'h80FF_7F01, 1'b0, 32'h0000_007F, 3, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0012, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFF, 3, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0012, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_00FF, 3, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_80FF, 3, 1'b1, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_80FF, 3, 1'b1, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0003, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h8000_4000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h8000_3FFC, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 3, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h8000_0020, 32'h0000_1234, 1'b1, 1'b1, 32'h5566_7788, 1'b1, 32'h0, 3, 1'b1, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h8000_0024, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2, 1'b1, 1'b1, 32'hDEAD_BEEF};
      tbl[15] = '{1'b0, 2'd0, 1'b1, 32'h8000_0027, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_00DE, 3, 1'b1, 1'b0, 32'h0};

      // Power-on reset
      rst_n = 1'b0; init_en = 1'b1; pre_en = 1'b0; err_arm = 1'b0; pre_idx = 0; pre_val = 0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", 0, {26'h0, req_ready, rsp_valid, rsp_err, dm_valid, dm_ren, dm_wen}, 32'h0);
      check("reset_dm_addr", 0, dm_addr, 32'h0);
      check("reset_rsp_rdata", 0, rsp_rdata, 32'h0);
      init_en = 1'b0;
      for (int i = 0; i < TB_NW; i++) ref_mem[i] = hash(i);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].pre) preload(tbl[i].addr, tbl[i].pv);
         do_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].inj);
         model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].inj,
               m_e, m_rd, m_lat, m_idx, m_wrote);
         check("vec_err", i, 32'(r_err), 32'(tbl[i].err));
         check("vec_rdata", i, r_rdata, tbl[i].rdata);
         check("vec_latency", i, 32'(r_lat), 32'(tbl[i].lat));
         check("vec_dm_valid_seen", i, 32'(r_dmv), 32'(tbl[i].dmv));
         check("vec_dm_wen_seen", i, 32'(r_wen), 32'(tbl[i].wen));
         check("vec_pulse_ready", i, 32'(r_pulse_ok), 32'h1);
         if (tbl[i].wen) check("vec_dm_wdata", i, r_wd, tbl[i].wd);
         if (tbl[i].dmv) check("vec_dm_addr", i, r_da, tbl[i].addr & 32'hFFFF_FFFC);
      end
      check("err_store_mem_kept", 13, mem[8], 32'h5566_7788);

      // Randomized traffic against the reference model
      for (int k = 0; k < 200; k++) begin
         we    = 1'($urandom);
         sz    = ($urandom_range(15, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
         uns   = 1'($urandom);
         wdata = $urandom;
         inj   = ($urandom_range(7, 0) == 0);
         case ($urandom_range(9, 0))
            0:       addr = $urandom;
            1:       addr = 32'h8000_4000 - 32'($urandom_range(8, 1));
            2:       addr = 32'h8000_0000 - 32'($urandom_range(4, 0));
            default: addr = 32'h8000_0000 + 32'($urandom_range(63, 0));
         endcase
         do_req(we, sz, uns, addr, wdata, inj);
         model(we, sz, uns, addr, wdata, inj, m_e, m_rd, m_lat, m_idx, m_wrote);
         check("rnd_err", k, 32'(r_err), 32'(m_e));
         check("rnd_rdata", k, r_rdata, m_rd);
         check("rnd_latency", k, 32'(r_lat), 32'(m_lat));
         if (m_wrote) check("rnd_mem", k, mem[m_idx], ref_mem[m_idx]);
      end

      // Reset while an access waits on memory
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000_0010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_ctl", 0, {26'h0, req_ready, rsp_valid, rsp_err, dm_valid, dm_ren, dm_wen}, 32'h0);
      check("midrst_dm_addr", 0, dm_addr, 32'h0);
      check("midrst_dm_wdata", 0, dm_wdata, 32'h0);
      saw = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (rsp_valid) saw = 1'b1; end
      rst_n = 1'b1;
      repeat (3) begin @(posedge clk); #1; if (rsp_valid) saw = 1'b1; end
      check("midrst_no_rsp", 0, 32'(saw), 32'h0);
      check("midrst_ready", 0, 32'(req_ready), 32'h1);
      do_req(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
      model(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 1'b0, m_e, m_rd, m_lat, m_idx, m_wrote);
      check("midrst_lw_latency", 0, 32'(r_lat), 32'h3);
      check("midrst_lw_rdata", 0, r_rdata, m_rd);
      check("midrst_lw_err", 0, 32'(r_err), 32'h0);

      check("dm_protocol", 0, 32'(proto_bad), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
